constraint_sweep_sequencer: RTL and testbench



---
 rtl/sim_pkg.sv | 26 ++
 rtl/particle_window.sv | 99 +++++++++
 rtl/constraint_sweep_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_constraint_sweep_sequencer.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_pkg.sv
// ----------------------------------------------------------------------------
// sim_pkg
// Shared definitions for the cloth/rope simulator datapath.
//   DATA_W_DEF  : default coordinate width (Q12.20 signed fixed point)
//   FRAC_BITS   : number of fraction bits in a coordinate
//   ANCHOR_IDX  : index of the pinned particle, never written back
//   state_e     : sweep sequencer states
// ----------------------------------------------------------------------------
package sim_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int FRAC_BITS  = 20;
  localparam int ANCHOR_IDX = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_UP  = 3'd1,
    ST_RD_CUR = 3'd2,
    ST_RD_DN  = 3'd3,
    ST_LATCH  = 3'd4,
    ST_EVAL   = 3'd5,
    ST_WRITE  = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

endpackage

// File: rtl/particle_window.sv
// ----------------------------------------------------------------------------
// particle_window
// Three-particle sliding window (up, cur, down) plus the enforced result (res)
// used by the rope-constraint sweep. All registers clear on reset.
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_load_up/cur/down: capture RAM read data into the named register
//   i_copy_last       : down <- cur (last particle has no lower neighbour)
//   i_load_res        : res <- constraint-unit result
//   i_shift           : advance window: up <- res, cur <- down
//   i_rd_x/y          : RAM read data
//   i_res_x/y         : constraint-unit result
//   o_up/cur/down/res : register contents
// ----------------------------------------------------------------------------
module particle_window
  import sim_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load_up,
  input  logic              i_load_cur,
  input  logic              i_load_down,
  input  logic              i_copy_last,
  input  logic              i_load_res,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_rd_x,
  input  logic [DATA_W-1:0] i_rd_y,
  input  logic [DATA_W-1:0] i_res_x,
  input  logic [DATA_W-1:0] i_res_y,
  output logic [DATA_W-1:0] o_up_x,
  output logic [DATA_W-1:0] o_up_y,
  output logic [DATA_W-1:0] o_cur_x,
  output logic [DATA_W-1:0] o_cur_y,
  output logic [DATA_W-1:0] o_down_x,
  output logic [DATA_W-1:0] o_down_y,
  output logic [DATA_W-1:0] o_res_x,
  output logic [DATA_W-1:0] o_res_y
);

  logic [DATA_W-1:0] r_up_x, r_up_y;
  logic [DATA_W-1:0] r_cur_x, r_cur_y;
  logic [DATA_W-1:0] r_down_x, r_down_y;
  logic [DATA_W-1:0] r_res_x, r_res_y;

  // Window registers; the shift feeds res into up so the next particle sees
  // its already-updated upper neighbour (Gauss-Seidel order).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_up_x   <= '0;
      r_up_y   <= '0;
      r_cur_x  <= '0;
      r_cur_y  <= '0;
      r_down_x <= '0;
      r_down_y <= '0;
      r_res_x  <= '0;
      r_res_y  <= '0;
    end else begin
      if (i_load_up) begin
        r_up_x <= i_rd_x;
        r_up_y <= i_rd_y;
      end else if (i_shift) begin
        r_up_x <= r_res_x;
        r_up_y <= r_res_y;
      end

      if (i_load_cur) begin
        r_cur_x <= i_rd_x;
        r_cur_y <= i_rd_y;
      end else if (i_shift) begin
        r_cur_x <= r_down_x;
        r_cur_y <= r_down_y;
      end

      if (i_load_down) begin
        r_down_x <= i_rd_x;
        r_down_y <= i_rd_y;
      end else if (i_copy_last) begin
        r_down_x <= r_cur_x;
        r_down_y <= r_cur_y;
      end

      if (i_load_res) begin
        r_res_x <= i_res_x;
        r_res_y <= i_res_y;
      end
    end
  end

  assign o_up_x   = r_up_x;
  assign o_up_y   = r_up_y;
  assign o_cur_x  = r_cur_x;
  assign o_cur_y  = r_cur_y;
  assign o_down_x = r_down_x;
  assign o_down_y = r_down_y;
  assign o_res_x  = r_res_x;
  assign o_res_y  = r_res_y;

endmodule

// File: rtl/constraint_sweep_sequencer.sv
// ----------------------------------------------------------------------------
// constraint_sweep_sequencer
// Walks particles 1..N_PARTICLES-1 of the position RAM for ITERATIONS
// Gauss-Seidel sweeps, presenting (up, cur, down) to the external
// combinational constraint unit and writing the result back. Particle 0 is
// the pinned anchor and is only read.
//   clk, rst_n           : clock, asynchronous active-low reset
//   i_start              : begins a run (sampled in IDLE only)
//   o_busy / o_done      : run in progress / one-cycle completion pulse
//   o_mem_rd_*           : RAM read port, data returns on i_mem_rd_x/y 1 cycle later
//   o_mem_wr_*           : RAM write port
//   o_ec_*               : window presented to the constraint unit
//   o_ec_is_last         : current particle is N_PARTICLES-1
//   i_ec_res_x/y         : constraint-unit result, sampled at end of EVAL
// ----------------------------------------------------------------------------
module constraint_sweep_sequencer
  import sim_pkg::*;
#(
  parameter int N_PARTICLES = 16,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ITERATIONS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_rd_addr,
  input  logic [DATA_W-1:0] i_mem_rd_x,
  input  logic [DATA_W-1:0] i_mem_rd_y,
  output logic              o_mem_wr_en,
  output logic [ADDR_W-1:0] o_mem_wr_addr,
  output logic [DATA_W-1:0] o_mem_wr_x,
  output logic [DATA_W-1:0] o_mem_wr_y,
  output logic [DATA_W-1:0] o_ec_up_x,
  output logic [DATA_W-1:0] o_ec_up_y,
  output logic [DATA_W-1:0] o_ec_x,
  output logic [DATA_W-1:0] o_ec_y,
  output logic [DATA_W-1:0] o_ec_down_x,
  output logic [DATA_W-1:0] o_ec_down_y,
  output logic              o_ec_is_last,
  input  logic [DATA_W-1:0] i_ec_res_x,
  input  logic [DATA_W-1:0] i_ec_res_y
);

  localparam int IT_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  // Index compares are done one bit wider so idx+1 cannot wrap.
  localparam logic [ADDR_W:0]   LAST_IDX  = (ADDR_W+1)'(N_PARTICLES - 1);
  localparam logic [ADDR_W:0]   ONE_EXT   = (ADDR_W+1)'(1);
  localparam logic [IT_W-1:0]   LAST_ITER = IT_W'(ITERATIONS - 1);

  state_e            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [IT_W-1:0]   r_iter;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_is_last;

  logic [ADDR_W:0]   w_idx_ext;
  logic [ADDR_W:0]   w_idx_p1;
  logic              w_idx_lt_last;
  logic              w_idx_p1_lt_last;
  logic              w_load_up;
  logic              w_load_cur;
  logic              w_load_down;
  logic              w_copy_last;
  logic              w_load_res;
  logic              w_shift;

  assign w_idx_ext        = {1'b0, r_idx};
  assign w_idx_p1         = w_idx_ext + ONE_EXT;
  assign w_idx_lt_last    = (w_idx_ext < LAST_IDX);
  assign w_idx_p1_lt_last = (w_idx_p1 < LAST_IDX);

  // Window register controls decoded from the current state.
  always_comb begin
    w_load_up   = 1'b0;
    w_load_cur  = 1'b0;
    w_load_down = 1'b0;
    w_copy_last = 1'b0;
    w_load_res  = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_RD_CUR: w_load_up  = 1'b1;
      ST_RD_DN:  w_load_cur = 1'b1;
      ST_LATCH: begin
        if (w_idx_lt_last) begin
          w_load_down = 1'b1;
        end else begin
          w_copy_last = 1'b1;
        end
      end
      ST_EVAL:   w_load_res = 1'b1;
      ST_WRITE:  w_shift    = 1'b1;
      default:   w_shift    = 1'b0;
    endcase
  end

  // Sequencer FSM; strobes and addresses are registered on entry to the
  // state in which they must be seen by the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_iter    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_is_last <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state   <= ST_RD_UP;
            r_iter    <= '0;
            r_busy    <= 1'b1;
            r_rd_en   <= 1'b1;
            r_rd_addr <= ADDR_W'(ANCHOR_IDX);
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_RD_UP: begin
          r_state   <= ST_RD_CUR;
          r_rd_en   <= 1'b1;
          r_rd_addr <= ADDR_W'(1);
        end
        ST_RD_CUR: begin
          // idx becomes 1; the read issued in RD_DN fetches particle 2.
          r_state   <= ST_RD_DN;
          r_idx     <= ADDR_W'(1);
          r_is_last <= (LAST_IDX == ONE_EXT);
          if (ONE_EXT < LAST_IDX) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= ADDR_W'(2);
          end
        end
        ST_RD_DN: begin
          r_state <= ST_LATCH;
        end
        ST_LATCH: begin
          r_state <= ST_EVAL;
        end
        ST_EVAL: begin
          // Write idx while prefetching idx+2, the next particle's down.
          r_state   <= ST_WRITE;
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_idx;
          if (w_idx_p1_lt_last) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_idx + ADDR_W'(2);
          end
        end
        ST_WRITE: begin
          if (w_idx_lt_last) begin
            r_idx     <= r_idx + ADDR_W'(1);
            r_state   <= ST_LATCH;
            r_is_last <= (w_idx_p1 == LAST_IDX);
          end else if (r_iter < LAST_ITER) begin
            r_iter    <= r_iter + IT_W'(1);
            r_state   <= ST_RD_UP;
            r_is_last <= 1'b0;
            r_rd_en   <= 1'b1;
            r_rd_addr <= ADDR_W'(ANCHOR_IDX);
          end else begin
            r_state   <= ST_DONE;
            r_is_last <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  particle_window #(
    .DATA_W(DATA_W)
  ) u_window (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load_up  (w_load_up),
    .i_load_cur (w_load_cur),
    .i_load_down(w_load_down),
    .i_copy_last(w_copy_last),
    .i_load_res (w_load_res),
    .i_shift    (w_shift),
    .i_rd_x     (i_mem_rd_x),
    .i_rd_y     (i_mem_rd_y),
    .i_res_x    (i_ec_res_x),
    .i_res_y    (i_ec_res_y),
    .o_up_x     (o_ec_up_x),
    .o_up_y     (o_ec_up_y),
    .o_cur_x    (o_ec_x),
    .o_cur_y    (o_ec_y),
    .o_down_x   (o_ec_down_x),
    .o_down_y   (o_ec_down_y),
    .o_res_x    (o_mem_wr_x),
    .o_res_y    (o_mem_wr_y)
  );

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_mem_rd_en   = r_rd_en;
  assign o_mem_rd_addr = r_rd_addr;
  assign o_mem_wr_en   = r_wr_en;
  assign o_mem_wr_addr = r_wr_addr;
  assign o_ec_is_last  = r_is_last;

endmodule

// File: tb/tb_constraint_sweep_sequencer.sv
// ----------------------------------------------------------------------------
// tb_constraint_sweep_sequencer
// Three sequencer instances (N=3/I=1, N=16/I=4, N=2/I=1 with ADDR_W=1), each
// with a behavioural 1-cycle-latency RAM and a stub constraint unit that
// returns (ec_x, ec_y+1). Directed scenarios with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_constraint_sweep_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  int   sel;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // preload port into the bench RAMs
  logic        pre_en;
  int          pre_sel;
  logic [3:0]  pre_addr;
  logic [31:0] pre_x, pre_y;

  // ---------------- instance A: N=3, ITERATIONS=1 ----------------
  logic        busy_a, done_a, rd_en_a, wr_en_a, last_a;
  logic [3:0]  rd_addr_a, wr_addr_a;
  logic [31:0] rd_x_a, rd_y_a, wr_x_a, wr_y_a, ux_a, uy_a, cx_a, cy_a, dx_a, dy_a;
  logic [31:0] mx_a [16];
  logic [31:0] my_a [16];

  constraint_sweep_sequencer #(.N_PARTICLES(3), .ADDR_W(4), .DATA_W(32), .ITERATIONS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(start && (sel == 0)),
    .o_busy(busy_a), .o_done(done_a),
    .o_mem_rd_en(rd_en_a), .o_mem_rd_addr(rd_addr_a),
    .i_mem_rd_x(rd_x_a), .i_mem_rd_y(rd_y_a),
    .o_mem_wr_en(wr_en_a), .o_mem_wr_addr(wr_addr_a),
    .o_mem_wr_x(wr_x_a), .o_mem_wr_y(wr_y_a),
    .o_ec_up_x(ux_a), .o_ec_up_y(uy_a), .o_ec_x(cx_a), .o_ec_y(cy_a),
    .o_ec_down_x(dx_a), .o_ec_down_y(dy_a), .o_ec_is_last(last_a),
    .i_ec_res_x(cx_a), .i_ec_res_y(cy_a + 32'd1)
  );

  always @(posedge clk) begin
    if (pre_en && pre_sel == 0) begin
      mx_a[pre_addr] <= pre_x;
      my_a[pre_addr] <= pre_y;
    end else if (wr_en_a) begin
      mx_a[wr_addr_a] <= wr_x_a;
      my_a[wr_addr_a] <= wr_y_a;
    end
    if (rd_en_a) begin
      rd_x_a <= mx_a[rd_addr_a];
      rd_y_a <= my_a[rd_addr_a];
    end
  end

  // ---------------- instance B: N=16, ITERATIONS=4 ----------------
  logic        busy_b, done_b, rd_en_b, wr_en_b, last_b;
  logic [3:0]  rd_addr_b, wr_addr_b;
  logic [31:0] rd_x_b, rd_y_b, wr_x_b, wr_y_b, ux_b, uy_b, cx_b, cy_b, dx_b, dy_b;
  logic [31:0] mx_b [16];
  logic [31:0] my_b [16];

  constraint_sweep_sequencer #(.N_PARTICLES(16), .ADDR_W(4), .DATA_W(32), .ITERATIONS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(start && (sel == 1)),
    .o_busy(busy_b), .o_done(done_b),
    .o_mem_rd_en(rd_en_b), .o_mem_rd_addr(rd_addr_b),
    .i_mem_rd_x(rd_x_b), .i_mem_rd_y(rd_y_b),
    .o_mem_wr_en(wr_en_b), .o_mem_wr_addr(wr_addr_b),
    .o_mem_wr_x(wr_x_b), .o_mem_wr_y(wr_y_b),
    .o_ec_up_x(ux_b), .o_ec_up_y(uy_b), .o_ec_x(cx_b), .o_ec_y(cy_b),
    .o_ec_down_x(dx_b), .o_ec_down_y(dy_b), .o_ec_is_last(last_b),
    .i_ec_res_x(cx_b), .i_ec_res_y(cy_b + 32'd1)
  );

  always @(posedge clk) begin
    if (pre_en && pre_sel == 1) begin
      mx_b[pre_addr] <= pre_x;
      my_b[pre_addr] <= pre_y;
    end else if (wr_en_b) begin
      mx_b[wr_addr_b] <= wr_x_b;
      my_b[wr_addr_b] <= wr_y_b;
    end
    if (rd_en_b) begin
      rd_x_b <= mx_b[rd_addr_b];
      rd_y_b <= my_b[rd_addr_b];
    end
  end

  // ---------------- instance C: N=2, ITERATIONS=1, ADDR_W=1 ----------------
  logic        busy_c, done_c, rd_en_c, wr_en_c, last_c;
  logic [0:0]  rd_addr_c, wr_addr_c;
  logic [31:0] rd_x_c, rd_y_c, wr_x_c, wr_y_c, ux_c, uy_c, cx_c, cy_c, dx_c, dy_c;
  logic [31:0] mx_c [2];
  logic [31:0] my_c [2];

  constraint_sweep_sequencer #(.N_PARTICLES(2), .ADDR_W(1), .DATA_W(32), .ITERATIONS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .i_start(start && (sel == 2)),
    .o_busy(busy_c), .o_done(done_c),
    .o_mem_rd_en(rd_en_c), .o_mem_rd_addr(rd_addr_c),
    .i_mem_rd_x(rd_x_c), .i_mem_rd_y(rd_y_c),
    .o_mem_wr_en(wr_en_c), .o_mem_wr_addr(wr_addr_c),
    .o_mem_wr_x(wr_x_c), .o_mem_wr_y(wr_y_c),
    .o_ec_up_x(ux_c), .o_ec_up_y(uy_c), .o_ec_x(cx_c), .o_ec_y(cy_c),
    .o_ec_down_x(dx_c), .o_ec_down_y(dy_c), .o_ec_is_last(last_c),
    .i_ec_res_x(cx_c), .i_ec_res_y(cy_c + 32'd1)
  );

  always @(posedge clk) begin
    if (pre_en && pre_sel == 2) begin
      mx_c[pre_addr[0]] <= pre_x;
      my_c[pre_addr[0]] <= pre_y;
    end else if (wr_en_c) begin
      mx_c[wr_addr_c] <= wr_x_c;
      my_c[wr_addr_c] <= wr_y_c;
    end
    if (rd_en_c) begin
      rd_x_c <= mx_c[rd_addr_c];
      rd_y_c <= my_c[rd_addr_c];
    end
  end

  // ---------------- view of the selected instance ----------------
  logic        s_busy, s_done, s_rd_en, s_wr_en, s_last;
  logic [3:0]  s_rd_addr, s_wr_addr;
  logic [31:0] s_wr_x, s_wr_y, s_ux, s_uy, s_cx, s_cy, s_dx, s_dy;

  always_comb begin
    case (sel)
      0: begin
        s_busy = busy_a; s_done = done_a; s_rd_en = rd_en_a; s_wr_en = wr_en_a; s_last = last_a;
        s_rd_addr = rd_addr_a; s_wr_addr = wr_addr_a; s_wr_x = wr_x_a; s_wr_y = wr_y_a;
        s_ux = ux_a; s_uy = uy_a; s_cx = cx_a; s_cy = cy_a; s_dx = dx_a; s_dy = dy_a;
      end
      1: begin
        s_busy = busy_b; s_done = done_b; s_rd_en = rd_en_b; s_wr_en = wr_en_b; s_last = last_b;
        s_rd_addr = rd_addr_b; s_wr_addr = wr_addr_b; s_wr_x = wr_x_b; s_wr_y = wr_y_b;
        s_ux = ux_b; s_uy = uy_b; s_cx = cx_b; s_cy = cy_b; s_dx = dx_b; s_dy = dy_b;
      end
      default: begin
        s_busy = busy_c; s_done = done_c; s_rd_en = rd_en_c; s_wr_en = wr_en_c; s_last = last_c;
        s_rd_addr = {3'd0, rd_addr_c}; s_wr_addr = {3'd0, wr_addr_c}; s_wr_x = wr_x_c; s_wr_y = wr_y_c;
        s_ux = ux_c; s_uy = uy_c; s_cx = cx_c; s_cy = cy_c; s_dx = dx_c; s_dy = dy_c;
      end
    endcase
  end

  // write log filled by run_sel
  logic [3:0]  lg_addr [64];
  logic [31:0] lg_x [64];
  logic [31:0] lg_y [64];
  logic        lg_last [64];
  logic        lg_down_eq [64];
  logic [31:0] lg_ux [64];
  logic [31:0] lg_uy [64];

  task automatic preload(input int s, input logic [3:0] a, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    pre_sel  = s;
    pre_en   = 1'b1;
    pre_addr = a;
    pre_x    = x;
    pre_y    = y;
    @(posedge clk);
    #1;
    pre_en = 1'b0;
  endtask

  task automatic preload_b_zero_y();
    for (int i = 0; i < 16; i++) begin
      preload(1, 4'(i), 32'h100 * 32'(i), 32'd0);
    end
  endtask

  // Pulses start for the selected instance and watches until done (bounded).
  // done_cyc counts cycle 1 as the cycle after start is sampled; 0 means timeout.
  task automatic run_sel(input int s, input int extra_start_cyc, output int done_cyc,
                         output int nwr, output int clash, output int wr0);
    sel = s;
    done_cyc = 0;
    nwr = 0;
    clash = 0;
    wr0 = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 400; c++) begin
      #1;
      if (c == 1) start = 1'b0;
      if (c == extra_start_cyc) start = 1'b1;
      if (c == extra_start_cyc + 1) start = 1'b0;
      if (s_wr_en) begin
        if (nwr < 64) begin
          lg_addr[nwr]    = s_wr_addr;
          lg_x[nwr]       = s_wr_x;
          lg_y[nwr]       = s_wr_y;
          lg_last[nwr]    = s_last;
          lg_down_eq[nwr] = (s_dx === s_cx) && (s_dy === s_cy);
          lg_ux[nwr]      = s_ux;
          lg_uy[nwr]      = s_uy;
        end
        if (s_wr_addr == 4'd0) wr0++;
        nwr++;
      end
      if (s_rd_en && s_wr_en && (s_rd_addr == s_wr_addr)) clash++;
      if (s_done) begin
        done_cyc = c;
        break;
      end
      @(posedge clk);
    end
    if (done_cyc == 0) begin
      n_checks++; n_errors++;
      $display("FAIL run_timeout: sel=%0d no done within 400 cycles", s);
    end
    start = 1'b0;
    // done must be a single-cycle pulse followed by IDLE
    @(posedge clk);
    #1;
    n_checks++;
    if (s_done !== 1'b0 || s_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL done_pulse: sel=%0d done=%b busy=%b, required 0/0", s, s_done, s_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    pre_en = 1'b0;
    pre_sel = 0;
    pre_addr = 4'd0;
    pre_x = 32'd0;
    pre_y = 32'd0;
    sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      n_checks++;
      if (s_busy !== 1'b0 || s_done !== 1'b0 || s_rd_en !== 1'b0 || s_wr_en !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_strobes: sel=%0d busy=%b done=%b rd=%b wr=%b, required all 0",
                 s, s_busy, s_done, s_rd_en, s_wr_en);
      end
      n_checks++;
      if (s_ux !== 32'd0 || s_cy !== 32'd0 || s_dx !== 32'd0 || s_last !== 1'b0 || s_wr_y !== 32'd0) begin
        n_errors++;
        $display("FAIL reset_window: sel=%0d up_x=%h cur_y=%h down_x=%h last=%b wr_y=%h, required 0",
                 s, s_ux, s_cy, s_dx, s_last, s_wr_y);
      end
    end
  endtask

  task automatic test_n3_single_sweep();
    int dc, nw, cl, w0;
    preload(0, 4'd0, 32'h000c9b36, 32'h000aae67);
    preload(0, 4'd1, 32'h000c9b36, 32'h000b4e67);
    preload(0, 4'd2, 32'h000c9b36, 32'h000c3e67);
    run_sel(0, -10, dc, nw, cl, w0);
    n_checks++;
    if (dc !== 10) begin n_errors++; $display("FAIL n3_done_cycle: got %0d required 10", dc); end
    n_checks++;
    if (nw !== 2) begin n_errors++; $display("FAIL n3_write_count: got %0d required 2", nw); end
    if (nw >= 2) begin
      n_checks++;
      if (lg_addr[0] !== 4'd1 || lg_x[0] !== 32'h000c9b36 || lg_y[0] !== 32'h000b4e68) begin
        n_errors++;
        $display("FAIL n3_write1: got addr=%0d (%h,%h) required addr=1 (000c9b36,000b4e68)", lg_addr[0], lg_x[0], lg_y[0]);
      end
      n_checks++;
      if (lg_addr[1] !== 4'd2 || lg_x[1] !== 32'h000c9b36 || lg_y[1] !== 32'h000c3e68) begin
        n_errors++;
        $display("FAIL n3_write2: got addr=%0d (%h,%h) required addr=2 (000c9b36,000c3e68)", lg_addr[1], lg_x[1], lg_y[1]);
      end
      n_checks++;
      if (lg_last[1] !== 1'b1 || lg_down_eq[1] !== 1'b1) begin
        n_errors++;
        $display("FAIL n3_last_window: got is_last=%b down_eq_cur=%b required 1/1", lg_last[1], lg_down_eq[1]);
      end
      n_checks++;
      if (lg_last[0] !== 1'b0) begin
        n_errors++;
        $display("FAIL n3_first_not_last: got is_last=%b required 0", lg_last[0]);
      end
      // particle 2 must see the already-updated particle 1 as its up neighbour
      n_checks++;
      if (lg_ux[1] !== 32'h000c9b36 || lg_uy[1] !== 32'h000b4e68) begin
        n_errors++;
        $display("FAIL n3_gauss_seidel_up: got (%h,%h) required (000c9b36,000b4e68)", lg_ux[1], lg_uy[1]);
      end
    end
    n_checks++;
    if (w0 !== 0 || my_a[0] !== 32'h000aae67) begin
      n_errors++;
      $display("FAIL n3_anchor: got writes=%0d y0=%h required 0 writes y0=000aae67", w0, my_a[0]);
    end
    n_checks++;
    if (cl !== 0) begin n_errors++; $display("FAIL n3_rw_clash: got %0d required 0", cl); end
  endtask

  task automatic check_b_result(input string tag, input int dc, input int nw, input int cl, input int w0);
    n_checks++;
    if (dc !== 193) begin n_errors++; $display("FAIL %s_done_cycle: got %0d required 193", tag, dc); end
    n_checks++;
    if (nw !== 60) begin n_errors++; $display("FAIL %s_write_count: got %0d required 60", tag, nw); end
    n_checks++;
    if (w0 !== 0 || cl !== 0) begin
      n_errors++;
      $display("FAIL %s_anchor_clash: got addr0 writes=%0d clashes=%0d required 0/0", tag, w0, cl);
    end
    n_checks++;
    if (my_b[0] !== 32'd0) begin n_errors++; $display("FAIL %s_anchor_y: got %h required 0", tag, my_b[0]); end
    for (int i = 1; i < 16; i++) begin
      n_checks++;
      if (my_b[i] !== 32'd4 || mx_b[i] !== 32'h100 * 32'(i)) begin
        n_errors++;
        $display("FAIL %s_particle%0d: got (%h,%h) required (%h,00000004)", tag, i, mx_b[i], my_b[i], 32'h100 * 32'(i));
      end
    end
  endtask

  task automatic test_n16_four_sweeps();
    int dc, nw, cl, w0;
    preload_b_zero_y();
    run_sel(1, -10, dc, nw, cl, w0);
    check_b_result("n16", dc, nw, cl, w0);
  endtask

  task automatic test_start_while_busy();
    int dc, nw, cl, w0;
    preload_b_zero_y();
    run_sel(1, 20, dc, nw, cl, w0);
    check_b_result("busy_start", dc, nw, cl, w0);
  endtask

  task automatic test_reset_mid_write();
    int dc, nw, cl, w0;
    int seen;
    preload_b_zero_y();
    sel = 1;
    seen = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 50; c++) begin
      #1;
      start = 1'b0;
      if (s_wr_en) begin
        seen = 1;
        break;
      end
      @(posedge clk);
    end
    n_checks++;
    if (seen !== 1) begin n_errors++; $display("FAIL midrst_reach_write: got %0d required 1", seen); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (s_busy !== 1'b0 || s_wr_en !== 1'b0 || s_rd_en !== 1'b0 || s_done !== 1'b0 || s_last !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_strobes: busy=%b wr=%b rd=%b done=%b last=%b required all 0",
               s_busy, s_wr_en, s_rd_en, s_done, s_last);
    end
    n_checks++;
    if (s_ux !== 32'd0 || s_cx !== 32'd0 || s_dx !== 32'd0 || s_wr_x !== 32'd0 || s_wr_addr !== 4'd0) begin
      n_errors++;
      $display("FAIL midrst_window: up_x=%h cur_x=%h down_x=%h wr_x=%h wr_addr=%0d required 0",
               s_ux, s_cx, s_dx, s_wr_x, s_wr_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (s_busy !== 1'b0 || s_rd_en !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_idle: busy=%b rd=%b required 0/0", s_busy, s_rd_en);
    end
    preload_b_zero_y();
    run_sel(1, -10, dc, nw, cl, w0);
    check_b_result("after_rst", dc, nw, cl, w0);
  endtask

  task automatic test_n2_boundary();
    int dc, nw, cl, w0;
    preload(2, 4'd0, 32'h00000003, 32'h00000005);
    preload(2, 4'd1, 32'h00000007, 32'h00000009);
    run_sel(2, -10, dc, nw, cl, w0);
    n_checks++;
    if (dc !== 7) begin n_errors++; $display("FAIL n2_done_cycle: got %0d required 7", dc); end
    n_checks++;
    if (nw !== 1) begin n_errors++; $display("FAIL n2_write_count: got %0d required 1", nw); end
    if (nw >= 1) begin
      n_checks++;
      if (lg_addr[0] !== 4'd1 || lg_x[0] !== 32'h00000007 || lg_y[0] !== 32'h0000000a ||
          lg_last[0] !== 1'b1 || lg_down_eq[0] !== 1'b1) begin
        n_errors++;
        $display("FAIL n2_write: got addr=%0d (%h,%h) last=%b down_eq=%b required addr=1 (00000007,0000000a) 1 1",
                 lg_addr[0], lg_x[0], lg_y[0], lg_last[0], lg_down_eq[0]);
      end
      n_checks++;
      if (lg_ux[0] !== 32'h00000003 || lg_uy[0] !== 32'h00000005) begin
        n_errors++;
        $display("FAIL n2_up: got (%h,%h) required (00000003,00000005)", lg_ux[0], lg_uy[0]);
      end
    end
    n_checks++;
    if (my_c[0] !== 32'h00000005 || my_c[1] !== 32'h0000000a) begin
      n_errors++;
      $display("FAIL n2_ram: got y0=%h y1=%h required 00000005/0000000a", my_c[0], my_c[1]);
    end
  endtask

  initial begin
    test_reset();
    test_n3_single_sweep();
    test_n16_four_sweeps();
    test_start_while_busy();
    test_reset_mid_write();
    test_n2_boundary();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
